// File: rtl/hamming74_serial_encoder_if.sv
// hamming74_serial_encoder_if: nibble handshake, error injection and serial link signals of the Hamming(7,4) encoder
//   in_valid/in_ready/in_data      nibble push handshake (push when valid && ready)
//   inject_en/inject_pos           flip one codeword bit at load time (pos 7 = none)
//   ser_ena/ser_bit/frame_start    serial link to the decoder, 8 slots per frame
//   busy/codeword/fifo_count       status and debug
interface hamming74_serial_encoder_if #(
   parameter int FIFO_DEPTH = 4
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   logic          in_valid;
   logic          in_ready;
   logic [3:0]    in_data;
   logic          inject_en;
   logic [2:0]    inject_pos;
   logic          ser_ena;
   logic          ser_bit;
   logic          frame_start;
   logic          busy;
   logic [6:0]    codeword;
   logic [CW-1:0] fifo_count;
   modport master (
      output in_valid, in_data, inject_en, inject_pos,
      input  in_ready, ser_ena, ser_bit, frame_start, busy, codeword, fifo_count
   );
   modport slave (
      input  in_valid, in_data, inject_en, inject_pos,
      output in_ready, ser_ena, ser_bit, frame_start, busy, codeword, fifo_count
   );
endinterface

// File: rtl/hamming74_serial_encoder.sv
// hamming74_serial_encoder: FIFO-buffered Hamming(7,4) encoder feeding a bit-serial decoder in 8-slot frames
//   clk, rst  clock and synchronous active-high reset
//   bus       slave side of hamming74_serial_encoder_if (handshake in, serial link out)
module hamming74_serial_encoder #(
   parameter int FIFO_DEPTH = 4,
   parameter int IDLE_GAP   = 0
) (
   input logic                       clk,
   input logic                       rst,
   hamming74_serial_encoder_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
   localparam logic [15:0] GAP_LAST = 16'(IDLE_GAP - 1);
   typedef enum logic [1:0] {IDLE, SHIFT, DECODE, GAP} state_t;
   state_t state, state_nx;
   logic [3:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic [2:0] slot;
   logic [15:0] gap_cnt;
   logic [6:0] cw, flip;
   logic push, pop, empty, full;

   function automatic logic [6:0] encode(input logic [3:0] d);
      return {d[3] ^ d[2] ^ d[0], d[3] ^ d[1] ^ d[0], d[3], d[2] ^ d[1] ^ d[0], d[2], d[1], d[0]};
   endfunction

   assign empty = count == '0;
   assign full  = count == FULL;
   // no bypass: a pop in the same cycle never opens in_ready while full
   assign push  = bus.in_valid && !full;
   assign flip  = bus.inject_en && bus.inject_pos != 3'd7 ? 7'b1 << bus.inject_pos : '0;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // pop doubles as the codeword load strobe; every load restarts a frame
   always_comb begin
      state_nx = state;
      pop      = 1'b0;
      case (state)
         IDLE:    pop = !empty;
         SHIFT:   state_nx = slot == 3'd6 ? DECODE : SHIFT;
         DECODE: begin
            pop      = IDLE_GAP == 0 && !empty;
            state_nx = IDLE_GAP > 0 ? GAP : IDLE;
         end
         GAP: begin
            pop      = gap_cnt == GAP_LAST && !empty;
            state_nx = gap_cnt == GAP_LAST ? IDLE : GAP;
         end
      endcase
      if (pop) state_nx = SHIFT;
   end

   // the DECODE slot drives a zero so the decoder's own slot counter sees 8 strobes per frame
   always_comb begin
      bus.ser_ena     = state == SHIFT || state == DECODE;
      bus.ser_bit     = state == SHIFT && cw[slot];
      bus.frame_start = state == SHIFT && slot == 3'd0;
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.in_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         slot    <= '0;
         gap_cnt <= '0;
         cw      <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            cw     <= encode(mem[rd_ptr]) ^ flip;
         end
         count   <= count + CW'(push) - CW'(pop);
         slot    <= pop ? 3'd0 : slot + 3'd1;
         gap_cnt <= state == GAP ? gap_cnt + 16'd1 : '0;
      end
   end

   assign bus.in_ready   = !full;
   assign bus.busy       = state != IDLE || !empty;
   assign bus.codeword   = cw;
   assign bus.fifo_count = count;
endmodule

// File: tb/tb_hamming74_serial_encoder.sv
// tb_hamming74_serial_encoder: directed and scoreboard checks of the encoder through a behavioural serial decoder
module tb_hamming74_serial_encoder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int total = 0;
   int bad = 0;
   always #5 clk = ~clk;

   hamming74_serial_encoder_if #(.FIFO_DEPTH(4)) bus();
   hamming74_serial_encoder #(.FIFO_DEPTH(4), .IDLE_GAP(0)) dut (.clk(clk), .rst(rst), .bus(bus));

   // behavioural chained decoder: free-running 3-bit slot counter advanced by ser_ena
   logic [6:0] sh;
   logic [2:0] dslot;
   logic [3:0] dec_data [2048];
   logic [2:0] dec_syn [2048];
   int dec_n = 0;
   int rd = 0;

   function automatic logic [2:0] syn_of(input logic [6:0] c);
      return {c[6] ^ c[4] ^ c[2] ^ c[0], c[5] ^ c[4] ^ c[1] ^ c[0], c[3] ^ c[2] ^ c[1] ^ c[0]};
   endfunction

   function automatic logic [3:0] fix(input logic [6:0] c);
      logic [6:0] f;
      f = c;
      case (syn_of(c))
         3'd7: f[0] = ~f[0];
         3'd3: f[1] = ~f[1];
         3'd5: f[2] = ~f[2];
         3'd6: f[4] = ~f[4];
         default: ;
      endcase
      return {f[4], f[2], f[1], f[0]};
   endfunction

   always @(posedge clk) begin
      if (rst) dslot <= 3'd0;
      else if (bus.ser_ena) begin
         if (dslot == 3'd7) begin
            dec_data[dec_n] <= fix(sh);
            dec_syn[dec_n]  <= syn_of(sh);
            dec_n <= dec_n + 1;
         end else sh[dslot] <= bus.ser_bit;
         dslot <= dslot + 3'd1;
      end
   end

   task automatic push(input logic [3:0] d);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data = 4'h0;
      bus.inject_en = 1'b0;
      bus.inject_pos = 3'd7;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset in_ready got %b want 1", bus.in_ready); end
      total++; if (bus.ser_ena !== 1'b0) begin bad++; $display("FAIL reset ser_ena got %b want 0", bus.ser_ena); end
      total++; if (bus.ser_bit !== 1'b0) begin bad++; $display("FAIL reset ser_bit got %b want 0", bus.ser_bit); end
      total++; if (bus.frame_start !== 1'b0) begin bad++; $display("FAIL reset frame_start got %b want 0", bus.frame_start); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset busy got %b want 0", bus.busy); end
      total++; if (bus.codeword !== 7'h00) begin bad++; $display("FAIL reset codeword got %h want 00", bus.codeword); end
      total++; if (bus.fifo_count !== 3'd0) begin bad++; $display("FAIL reset fifo_count got %0d want 0", bus.fifo_count); end
   endtask

   task automatic test_single;
      logic [7:0] e;
      e = 8'h33;
      push(4'b1011);
      @(negedge clk);
      total++; if (bus.codeword !== 7'h33) begin bad++; $display("FAIL single codeword got %h want 33", bus.codeword); end
      for (int i = 0; i < 8; i++) begin
         total++;
         if ({bus.ser_ena, bus.ser_bit, bus.frame_start} !== {1'b1, e[i], i == 0}) begin
            bad++; $display("FAIL single slot%0d ena/bit/start got %b want %b", i, {bus.ser_ena, bus.ser_bit, bus.frame_start}, {1'b1, e[i], i == 0});
         end
         @(negedge clk);
      end
      total++; if ({bus.ser_ena, bus.busy} !== 2'b00) begin bad++; $display("FAIL single after-frame ena/busy got %b want 00", {bus.ser_ena, bus.busy}); end
      total++; if (dec_n !== rd + 1) begin bad++; $display("FAIL single decoded count got %0d want %0d", dec_n, rd + 1); end
      total++; if ({dec_data[rd], dec_syn[rd]} !== {4'b1011, 3'b000}) begin bad++; $display("FAIL single decode data/syn got %h/%b want b/000", dec_data[rd], dec_syn[rd]); end
      rd = dec_n;
   endtask

   task automatic test_back_to_back;
      logic [6:0] cws [3];
      logic [3:0] nib [3];
      cws = '{7'h00, 7'h7F, 7'h69};
      nib = '{4'h0, 4'hF, 4'h1};
      bus.in_valid = 1'b1;
      bus.in_data = 4'h0;
      @(negedge clk);
      bus.in_data = 4'hF;
      @(negedge clk);
      bus.in_data = 4'h1;
      for (int i = 0; i < 24; i++) begin
         if (i == 1) bus.in_valid = 1'b0;
         total++;
         if ({bus.ser_ena, bus.frame_start} !== {1'b1, i % 8 == 0}) begin
            bad++; $display("FAIL b2b cycle%0d ena/start got %b want %b", i, {bus.ser_ena, bus.frame_start}, {1'b1, i % 8 == 0});
         end
         if (i % 8 == 0) begin
            total++; if (bus.codeword !== cws[i / 8]) begin bad++; $display("FAIL b2b codeword%0d got %h want %h", i / 8, bus.codeword, cws[i / 8]); end
         end
         @(negedge clk);
      end
      total++; if (bus.ser_ena !== 1'b0) begin bad++; $display("FAIL b2b ser_ena after 24 got %b want 0", bus.ser_ena); end
      total++; if (dec_n !== rd + 3) begin bad++; $display("FAIL b2b decoded count got %0d want %0d", dec_n, rd + 3); end
      for (int k = 0; k < 3; k++) begin
         total++; if (dec_data[rd + k] !== nib[k]) begin bad++; $display("FAIL b2b decode%0d got %h want %h", k, dec_data[rd + k], nib[k]); end
      end
      rd = dec_n;
   endtask

   task automatic test_fill_stall;
      int n;
      logic [3:0] v;
      push(4'h5);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data = 4'h6;
      repeat (4) begin
         @(negedge clk);
         bus.in_data = bus.in_data + 4'h1;
      end
      total++; if ({bus.in_ready, bus.fifo_count} !== {1'b0, 3'd4}) begin bad++; $display("FAIL full ready/count got %b/%0d want 0/4", bus.in_ready, bus.fifo_count); end
      n = 0;
      while (!bus.in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      total++; if (n !== 4) begin bad++; $display("FAIL full cycles-until-ready got %0d want 4", n); end
      total++; if (bus.fifo_count !== 3'd3) begin bad++; $display("FAIL full count after pop got %0d want 3", bus.fifo_count); end
      @(negedge clk);
      bus.in_valid = 1'b0;
      total++; if ({bus.in_ready, bus.fifo_count} !== {1'b0, 3'd4}) begin bad++; $display("FAIL full refill ready/count got %b/%0d want 0/4", bus.in_ready, bus.fifo_count); end
      n = 0;
      while (bus.busy && n < 300) begin
         @(negedge clk);
         n++;
      end
      total++; if (n >= 300) begin bad++; $display("FAIL full drain timeout busy got %b want 0", bus.busy); end
      total++; if (dec_n !== rd + 6) begin bad++; $display("FAIL full decoded count got %0d want %0d", dec_n, rd + 6); end
      v = 4'h5;
      for (int k = 0; k < 6; k++) begin
         total++; if (dec_data[rd + k] !== v) begin bad++; $display("FAIL full order%0d got %h want %h", k, dec_data[rd + k], v); end
         v = v + 4'h1;
      end
      rd = dec_n;
   endtask

   task automatic test_inject;
      bus.inject_en = 1'b1;
      bus.inject_pos = 3'd2;
      push(4'b1011);
      @(negedge clk);
      bus.inject_en = 1'b0;
      bus.inject_pos = 3'd7;
      total++; if (bus.codeword !== 7'h37) begin bad++; $display("FAIL inject2 codeword got %h want 37", bus.codeword); end
      repeat (8) @(negedge clk);
      total++; if ({dec_data[rd], dec_syn[rd]} !== {4'b1011, 3'b101}) begin bad++; $display("FAIL inject2 decode data/syn got %h/%b want b/101", dec_data[rd], dec_syn[rd]); end
      rd = dec_n;
      bus.inject_en = 1'b1;
      bus.inject_pos = 3'd7;
      push(4'b1011);
      @(negedge clk);
      bus.inject_en = 1'b0;
      total++; if (bus.codeword !== 7'h33) begin bad++; $display("FAIL inject7 codeword got %h want 33", bus.codeword); end
      repeat (8) @(negedge clk);
      total++; if ({dec_data[rd], dec_syn[rd]} !== {4'b1011, 3'b000}) begin bad++; $display("FAIL inject7 decode data/syn got %h/%b want b/000", dec_data[rd], dec_syn[rd]); end
      rd = dec_n;
      bus.inject_en = 1'b1;
      bus.inject_pos = 3'd0;
      push(4'b1011);
      bus.inject_en = 1'b0;
      bus.inject_pos = 3'd7;
      @(negedge clk);
      total++; if (bus.codeword !== 7'h33) begin bad++; $display("FAIL inject-at-push-only codeword got %h want 33", bus.codeword); end
      repeat (8) @(negedge clk);
      rd = dec_n;
   endtask

   task automatic test_reset_mid;
      bus.in_valid = 1'b1;
      bus.in_data = 4'h1;
      @(negedge clk);
      bus.in_data = 4'h2;
      @(negedge clk);
      bus.in_data = 4'h3;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      total++; if ({bus.ser_ena, bus.codeword, bus.fifo_count} !== {1'b1, 7'h69, 3'd2}) begin bad++; $display("FAIL midrst pre ena/cw/count got %b/%h/%0d want 1/69/2", bus.ser_ena, bus.codeword, bus.fifo_count); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++; if ({bus.ser_ena, bus.in_ready, bus.busy, bus.fifo_count} !== {1'b0, 1'b1, 1'b0, 3'd0}) begin
         bad++; $display("FAIL midrst post ena/ready/busy/count got %b%b%b/%0d want 010/0", bus.ser_ena, bus.in_ready, bus.busy, bus.fifo_count);
      end
      @(negedge clk);
      total++; if (bus.ser_ena !== 1'b0) begin bad++; $display("FAIL midrst no resume ser_ena got %b want 0", bus.ser_ena); end
      push(4'hC);
      @(negedge clk);
      total++; if ({bus.codeword, bus.frame_start} !== {7'h3C, 1'b1}) begin bad++; $display("FAIL midrst new frame cw/start got %h/%b want 3c/1", bus.codeword, bus.frame_start); end
      repeat (8) @(negedge clk);
      total++; if (dec_n !== rd + 1) begin bad++; $display("FAIL midrst decoded count got %0d want %0d", dec_n, rd + 1); end
      total++; if ({dec_data[rd], dec_syn[rd]} !== {4'hC, 3'b000}) begin bad++; $display("FAIL midrst decode data/syn got %h/%b want c/000", dec_data[rd], dec_syn[rd]); end
      rd = dec_n;
   endtask

   task automatic test_random;
      logic [3:0] exp_q [$];
      logic [3:0] d;
      int n;
      for (int k = 0; k < 500; k++) begin
         d = 4'($urandom());
         repeat ($urandom_range(0, 3)) @(negedge clk);
         bus.in_valid = 1'b1;
         bus.in_data = d;
         n = 0;
         while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
         end
         if (n >= 100) begin
            total++; bad++; $display("FAIL random in_ready timeout got 0 want 1");
         end
         @(negedge clk);
         bus.in_valid = 1'b0;
         exp_q.push_back(d);
      end
      n = 0;
      while (bus.busy && n < 1000) begin
         @(negedge clk);
         n++;
      end
      total++; if (n >= 1000) begin bad++; $display("FAIL random drain timeout busy got %b want 0", bus.busy); end
      total++; if (dec_n !== rd + 500) begin bad++; $display("FAIL random decoded count got %0d want %0d", dec_n, rd + 500); end
      for (int k = 0; k < 500; k++) begin
         total++; if (dec_data[rd + k] !== exp_q[k]) begin bad++; $display("FAIL random nibble%0d got %h want %h", k, dec_data[rd + k], exp_q[k]); end
      end
      rd = dec_n;
   endtask

   initial begin
      test_reset;
      test_single;
      test_back_to_back;
      test_fill_stall;
      test_inject;
      test_reset_mid;
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
